// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle instruction sequencer emitting Moore datapath strobes
// Latches one instruction per IDLE visit and walks it through DECODE/EXEC/MEM/WB, halting on memory timeout.
module multicycle_control_unit #(
    parameter int INST_W      = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [1:0]        i_op,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_immin,
    input  logic              i_mem_ready,
    output logic [INST_W+2:0] o_alu_code,
    output logic [INST_W+1:0] o_ext_sel,
    output logic              o_alu_en,
    output logic              o_wmem,
    output logic              o_rmem,
    output logic              o_wreg,
    output logic              o_wpc,
    output logic              o_jmp,
    output logic              o_busy,
    output logic              o_mem_err,
    output logic [CNT_W-1:0]  o_retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam int               WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [1:0]        r_op;
    logic [INST_W-1:0] r_inst;
    logic              r_immin;
    logic [WAIT_W-1:0] r_wait;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_retired;

    logic [2:0] w_next_state;
    logic       w_is_jmp;
    logic       w_is_nop;
    logic       w_is_store;
    logic       w_is_load;
    logic       w_is_mem;
    logic       w_is_alu;
    logic       w_is_wr;
    logic       w_accept;
    logic       w_wait_last;
    logic       w_wpc;

    // Instruction class is derived only from the latched fields.
    assign w_is_jmp    = (r_op == 2'b00);
    assign w_is_nop    = (r_op == 2'b01);
    assign w_is_store  = (r_op == 2'b10) && (r_inst == INST_W'(0)) && !r_immin;
    assign w_is_load   = (r_op == 2'b10) && (r_inst == INST_W'(1)) && !r_immin;
    assign w_is_mem    = w_is_store || w_is_load;
    assign w_is_alu    = !(w_is_jmp || w_is_nop || w_is_mem);
    assign w_is_wr     = (r_op == 2'b11) || ((r_op == 2'b10) && (r_inst != {INST_W{1'b1}}));
    assign w_accept    = (r_state == S_IDLE) && i_instr_valid;
    assign w_wait_last = (r_wait == WAIT_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_instr_valid) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_is_jmp || w_is_nop) begin
                    w_next_state = S_IDLE;
                end else if (w_is_mem) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            // A completion in the last allowed wait cycle still wins over the timeout.
            S_MEM: begin
                if (i_mem_ready) begin
                    w_next_state = S_WB;
                end else if (w_wait_last) begin
                    w_next_state = S_ERROR;
                end
            end
            S_WB:    w_next_state = S_IDLE;
            S_ERROR: w_next_state = S_ERROR;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_op      <= 2'b00;
            r_inst    <= '0;
            r_immin   <= 1'b0;
            r_wait    <= '0;
            r_mem_err <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op    <= i_op;
                r_inst  <= i_inst;
                r_immin <= i_immin;
            end
            if (r_state == S_EXEC) begin
                r_wait <= '0;
            end else if ((r_state == S_MEM) && !i_mem_ready && !w_wait_last) begin
                r_wait <= r_wait + 1'b1;
            end
            if ((r_state == S_MEM) && (w_next_state == S_ERROR)) begin
                r_mem_err <= 1'b1;
            end
            if (w_wpc) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign w_wpc = ((r_state == S_EXEC) && (w_is_jmp || w_is_nop)) || (r_state == S_WB);

    assign o_instr_ready = (r_state == S_IDLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_alu_en      = (r_state == S_EXEC);
    assign o_jmp         = (r_state == S_EXEC) && w_is_jmp;
    assign o_wpc         = w_wpc;
    assign o_wmem        = (r_state == S_MEM) && w_is_store;
    assign o_rmem        = (r_state == S_MEM) && w_is_load;
    assign o_wreg        = (r_state == S_WB) && (w_is_load || (w_is_alu && w_is_wr));
    assign o_mem_err     = r_mem_err;
    assign o_retired     = r_retired;
    assign o_alu_code    = {r_op, r_inst, r_immin};
    assign o_ext_sel     = {r_op, r_inst};

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - timeline reference model checks for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam int TO   = 4;
    localparam int CW   = 3;
    localparam int MAXN = 64;

    localparam int B_RDY  = 20;
    localparam int B_BUSY = 19;
    localparam int B_ALU  = 18;
    localparam int B_WM   = 17;
    localparam int B_RM   = 16;
    localparam int B_WR   = 15;
    localparam int B_PC   = 14;
    localparam int B_J    = 13;
    localparam int B_ERR  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [1:0]    op = 2'b00;
    logic [1:0]    inst = 2'b00;
    logic          immin = 1'b0;
    logic          mem_ready = 1'b0;
    logic [4:0]    alu_code;
    logic [3:0]    ext_sel;
    logic          alu_en, wmem, rmem, wreg, wpc, jmp, busy, mem_err;
    logic [CW-1:0] retired;

    multicycle_control_unit #(.INST_W(2), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
        .i_op(op), .i_inst(inst), .i_immin(immin), .i_mem_ready(mem_ready),
        .o_alu_code(alu_code), .o_ext_sel(ext_sel), .o_alu_en(alu_en), .o_wmem(wmem),
        .o_rmem(rmem), .o_wreg(wreg), .o_wpc(wpc), .o_jmp(jmp), .o_busy(busy),
        .o_mem_err(mem_err), .o_retired(retired)
    );

    always #5 clk = ~clk;

    bit          v_a   [MAXN];
    bit [1:0]    op_a  [MAXN];
    bit [1:0]    ins_a [MAXN];
    bit          imm_a [MAXN];
    bit          mr_a  [MAXN];
    logic [20:0] exp_a [MAXN];
    logic [20:0] got_a [MAXN];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [20:0] dut_vec();
        return {instr_ready, busy, alu_en, wmem, rmem, wreg, wpc, jmp, mem_err,
                alu_code, ext_sel, retired};
    endfunction

    function automatic logic [20:0] mk(bit rdy, bit bsy, bit alu, bit wm, bit rm, bit wr,
                                       bit pc, bit j, bit err, logic [4:0] code, logic [2:0] ret);
        return {rdy, bsy, alu, wm, rm, wr, pc, j, err, code, code[4:1], ret};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic clear_stim();
        for (int t = 0; t < MAXN; t++) begin
            v_a[t] = 0; op_a[t] = 0; ins_a[t] = 0; imm_a[t] = 0; mr_a[t] = 0;
            exp_a[t] = '0; got_a[t] = '0;
        end
    endtask

    // Expected output per cycle, laid out as a timeline of instruction phases.
    task automatic build_model(input int n);
        int t, c, k;
        logic [4:0] code;
        logic [2:0] ret;
        bit is_jmp, is_nop, is_st, is_ld, is_alu, wr;
        code = '0; ret = '0; t = 0;
        while (t < n) begin
            exp_a[t] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, code, ret);
            if (!v_a[t]) begin
                t++;
                continue;
            end
            code   = {op_a[t], ins_a[t], imm_a[t]};
            is_jmp = (op_a[t] == 2'd0);
            is_nop = (op_a[t] == 2'd1);
            is_st  = (code == 5'b10000);
            is_ld  = (code == 5'b10010);
            is_alu = !(is_jmp || is_nop || is_st || is_ld);
            wr     = (op_a[t] == 2'd3) || (op_a[t] == 2'd2 && ins_a[t] != 2'd3);
            if (t + 1 < n) exp_a[t+1] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, code, ret);
            if (is_jmp || is_nop) begin
                if (t + 2 < n) exp_a[t+2] = mk(0, 1, 1, 0, 0, 0, 1, is_jmp, 0, code, ret);
                ret = ret + 1'b1;
                t = t + 3;
            end else if (is_alu) begin
                if (t + 2 < n) exp_a[t+2] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, code, ret);
                if (t + 3 < n) exp_a[t+3] = mk(0, 1, 0, 0, 0, wr, 1, 0, 0, code, ret);
                ret = ret + 1'b1;
                t = t + 4;
            end else begin
                if (t + 2 < n) exp_a[t+2] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, code, ret);
                k = 0;
                forever begin
                    c = t + 3 + k;
                    if (c >= n) begin
                        t = n;
                        break;
                    end
                    exp_a[c] = mk(0, 1, 0, is_st, is_ld, 0, 0, 0, 0, code, ret);
                    if (mr_a[c]) begin
                        if (c + 1 < n) exp_a[c+1] = mk(0, 1, 0, 0, 0, is_ld, 1, 0, 0, code, ret);
                        ret = ret + 1'b1;
                        t = c + 2;
                        break;
                    end else if (k == TO - 1) begin
                        for (int e = c + 1; e < n; e++)
                            exp_a[e] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, code, ret);
                        t = n;
                        break;
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic run(input int n, input string tag);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            if (t > 0) @(negedge clk);
            got_a[t] = dut_vec();
            tests++;
            if (got_a[t] !== exp_a[t]) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, t, got_a[t], exp_a[t]);
            end
            instr_valid = v_a[t];
            op          = op_a[t];
            inst        = ins_a[t];
            immin       = imm_a[t];
            mem_ready   = mr_a[t];
        end
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1 chk({tag, "_async_reset"}, 32'(dut_vec()), 32'h100000);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic int count_bit(int n, int b);
        int cnt = 0;
        for (int t = 0; t < n; t++) cnt += int'(got_a[t][b]);
        return cnt;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dens;
        repeat (2) @(negedge clk);
        chk("power_on_reset", 32'(dut_vec()), 32'h100000);
        rst = 1'b1;

        clear_stim(); v_a[0] = 1; op_a[0] = 2'd0;
        run(6, "jmp");
        chk("jmp_c2_jmp", 32'(got_a[2][B_J]), 1);
        chk("jmp_c2_wpc", 32'(got_a[2][B_PC]), 1);
        chk("jmp_c2_alu", 32'(got_a[2][B_ALU]), 1);
        chk("jmp_c1_wpc", 32'(got_a[1][B_PC]), 0);
        chk("jmp_c3_retired", 32'(got_a[3][2:0]), 1);
        do_reset("jmp");

        clear_stim(); v_a[0] = 1; op_a[0] = 2'd3; ins_a[0] = 2'd1; imm_a[0] = 1;
        run(6, "alu_wr");
        chk("alu_wr_c3_wreg", 32'(got_a[3][B_WR]), 1);
        chk("alu_wr_c3_wpc", 32'(got_a[3][B_PC]), 1);
        chk("alu_wr_c2_wreg", 32'(got_a[2][B_WR]), 0);
        chk("alu_wr_code", 32'(got_a[3][11:7]), 32'b11011);
        chk("alu_wr_c4_ready", 32'(got_a[4][B_RDY]), 1);
        do_reset("alu_wr");

        clear_stim(); v_a[0] = 1; op_a[0] = 2'd2; ins_a[0] = 2'd3;
        run(6, "alu_nowr");
        chk("alu_nowr_c3_wpc", 32'(got_a[3][B_PC]), 1);
        chk("alu_nowr_c3_wreg", 32'(got_a[3][B_WR]), 0);
        chk("alu_nowr_mem", 32'(count_bit(6, B_WM) + count_bit(6, B_RM)), 0);
        do_reset("alu_nowr");

        clear_stim(); v_a[0] = 1; op_a[0] = 2'd2; ins_a[0] = 2'd1; mr_a[5] = 1;
        run(9, "load");
        chk("load_rmem_cycles", 32'(count_bit(9, B_RM)), 3);
        chk("load_c6_wreg", 32'(got_a[6][B_WR]), 1);
        chk("load_c7_ready", 32'(got_a[7][B_RDY]), 1);
        do_reset("load");

        clear_stim(); v_a[0] = 1; op_a[0] = 2'd2; ins_a[0] = 2'd0; mr_a[3] = 1;
        run(7, "store");
        chk("store_wmem_cycles", 32'(count_bit(7, B_WM)), 1);
        chk("store_c4_wpc", 32'(got_a[4][B_PC]), 1);
        chk("store_c4_wreg", 32'(got_a[4][B_WR]), 0);
        do_reset("store");

        clear_stim();
        for (int t = 0; t < 12; t++) begin v_a[t] = 1; op_a[t] = 2'd2; end
        run(12, "timeout");
        chk("timeout_wmem_cycles", 32'(count_bit(12, B_WM)), 4);
        chk("timeout_c7_err", 32'(got_a[7][B_ERR]), 1);
        chk("timeout_c7_ready", 32'(got_a[7][B_RDY]), 0);
        chk("timeout_c11_busy", 32'(got_a[11][B_BUSY]), 1);
        do_reset("timeout");

        clear_stim(); v_a[0] = 1; op_a[0] = 2'd2; mr_a[6] = 1;
        run(10, "last_wait");
        chk("last_wait_wmem_cycles", 32'(count_bit(10, B_WM)), 4);
        chk("last_wait_c7_wpc", 32'(got_a[7][B_PC]), 1);
        chk("last_wait_c9_err", 32'(got_a[9][B_ERR]), 0);
        do_reset("last_wait");

        clear_stim();
        for (int t = 0; t < 27; t++) begin v_a[t] = 1; op_a[t] = 2'd1; end
        run(30, "nop_wrap");
        chk("nop_wrap_retired", 32'(got_a[27][2:0]), 1);
        chk("nop_wrap_wpc_count", 32'(count_bit(30, B_PC)), 9);
        chk("nop_wrap_c26_wpc", 32'(got_a[26][B_PC]), 1);
        do_reset("nop_wrap");

        clear_stim(); v_a[0] = 1; op_a[0] = 2'd0; v_a[3] = 1; op_a[3] = 2'd3;
        run(6, "mid_exec");
        chk("mid_exec_c5_alu", 32'(got_a[5][B_ALU]), 1);
        chk("mid_exec_c5_retired", 32'(got_a[5][2:0]), 1);
        do_reset("mid_exec");

        for (int s = 0; s < 40; s++) begin
            clear_stim();
            n    = $urandom_range(20, MAXN);
            dens = $urandom_range(10, 90);
            for (int t = 0; t < n; t++) begin
                v_a[t]   = ($urandom_range(0, 3) != 0);
                op_a[t]  = 2'($urandom_range(0, 3));
                ins_a[t] = 2'($urandom_range(0, 3));
                imm_a[t] = ($urandom_range(0, 3) == 0);
                mr_a[t]  = ($urandom_range(0, 99) < dens);
            end
            run(n, "random");
            do_reset("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle control decoder: latches one instruction's opcode fields through a ready/valid handshake and sequences it through DECODE, EXEC, optional MEM wait, and WB. It emits the datapath strobes (`wmem`, `rmem`, `wreg`, `wpc`, `jmp`, `alu_en`) one state at a time. It adds a bounded memory-wait with a sticky error halt and a retired-instruction counter. It sits between instruction fetch and the CPU datapath, feeding the existing ALU and extend decoders through the latched `alu_code` and `ext_sel` fields.

## Interface
- `INST_W`, 2: width of the `inst` sub-opcode field.
- `MEM_TIMEOUT`, 15: maximum MEM-state cycles without `mem_ready` before a fault; legal range is 1 or more.
- `CNT_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  fetch is presenting an instruction.
- `instr_ready`  out  1  unit can accept an instruction.
- `op`  in  2  major opcode.
- `inst`  in  INST_W  sub-opcode.
- `immin`  in  1  immediate flag.
- `mem_ready`  in  1  data memory has completed the current access.
- `alu_code`  out  INST_W+3  latched `{op,inst,immin}`.
- `ext_sel`  out  INST_W+2  latched `{op,inst}`.
- `alu_en`  out  1  ALU result is valid this cycle.
- `wmem`, `rmem`, `wreg`, `wpc`, `jmp`  out  1 each  datapath strobes.
- `busy`  out  1  instruction in flight (state is not IDLE).
- `mem_err`  out  1  sticky memory-timeout fault.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
Instruction classes are decoded from the latched fields:
- **JMP**: `op==00`.
- **NOP**: `op==01`.
- **STORE**: `op==10`, `inst==0`, `immin==0`.
- **LOAD**: `op==10`, `inst==1`, `immin==0`.
- **ALU**: every other encoding.
- **WR** (writes a register): `op==11`, or `op==10` with `inst` not all-ones.

The FSM has states IDLE, DECODE, EXEC, MEM, WB, ERROR. Transitions:
- **IDLE**: `instr_ready=1`. When `instr_valid` is high, latch `op`, `inst`, `immin` and go to DECODE.
- **DECODE**: always goes to EXEC after one cycle.
- **EXEC**: `alu_en=1`.
  - JMP: also `jmp=1`, `wpc=1`; go to IDLE.
  - NOP: also `wpc=1`; go to IDLE.
  - STORE or LOAD: go to MEM.
  - ALU: go to WB.
- **MEM**: hold `wmem=1` (STORE) or `rmem=1` (LOAD) every cycle in this state.
  - The wait counter clears on entry.
  - If `mem_ready` is high, go to WB.
  - Otherwise, if wait counter equals `MEM_TIMEOUT-1`, go to ERROR and set `mem_err`.
  - Otherwise, increment the wait counter and stay.
- **WB**: `wpc=1`; `wreg=1` when the instruction is LOAD, or ALU with WR. Go to IDLE.
- **ERROR**: all strobes 0, `instr_ready=0`, `busy=1`, `mem_err=1`. The unit stays here until reset.

Output rules:
- All strobes are Moore outputs, decoded only from the state register and latched fields. No input-to-output combinational path exists.
- `retired` increments by 1 in every cycle where `wpc=1`, and wraps modulo 2^CNT_W.
- `alu_code` and `ext_sel` hold their value from the last accept until the next accept.

Reset (asserted at any time, including mid-instruction or in ERROR):
- State goes to IDLE immediately.
- Every output goes to 0 except `instr_ready`, which goes to 1.
- Latched fields, wait counter, `retired` and `mem_err` clear.

## Timing
- **Accept cycle**: cycle 0. Exactly one instruction is accepted per IDLE visit; `instr_valid` is ignored outside IDLE.
- **JMP/NOP**: DECODE in cycle 1, EXEC with `wpc` in cycle 2, IDLE in cycle 3. Three cycles per instruction.
- **ALU**: EXEC in cycle 2, WB in cycle 3, IDLE in cycle 4.
- **LOAD/STORE**: MEM is entered in cycle 3. If `mem_ready` is first high in MEM cycle k (k=0 is the first), WB occurs at cycle 4+k and IDLE at 5+k.
- **Timeout**: with `mem_ready` never high, MEM lasts exactly `MEM_TIMEOUT` cycles and ERROR starts in the next cycle.
- **Simultaneous events**: if `mem_ready` is high in the final timeout cycle, `mem_ready` wins and the unit goes to WB with no error.
- **`MEM_TIMEOUT=1`**: a single MEM cycle is allowed.

## Test plan
- **Reset**: drive `rst=0` mid-EXEC -> all strobes 0, `instr_ready=1`, `retired=0` in the same cycle. Release reset and accept a JMP (`op=00`) -> `jmp=wpc=alu_en=1` exactly in cycle 2, `retired=1`.
- **ALU write**: `op=11, inst=01, immin=1` -> `wreg=wpc=1` in cycle 3 only; `alu_code=5'b11011`; IDLE in cycle 4.
- **ALU with no register write**: `op=10, inst=11` -> WB has `wpc=1` and `wreg=0`; `wmem=rmem=0` throughout.
- **LOAD**: `op=10, inst=01, immin=0`, `mem_ready` high in the 3rd MEM cycle -> `rmem` high for 3 cycles, then `wreg=1` in WB. STORE with `mem_ready` on the first MEM cycle -> `wmem` high for 1 cycle, `wreg=0`.
- **Timeout** (`MEM_TIMEOUT=4`): `mem_ready` held low -> `wmem` high for exactly 4 cycles, then `mem_err=1`, `instr_ready=0` while `instr_valid` is held. Repeat with `mem_ready` high on the 4th MEM cycle -> no error, WB follows.
- **Counter wrap** (`CNT_W=3`): run 9 back-to-back NOPs with `instr_valid` constantly high -> `retired` reads 1 and one instruction completes every 3 cycles.
